// File: rtl/rice_partition_sequencer.sv
// ---------------------------------------------------------------------------
// rice_partition_sequencer
//
// Sequences one Rice-coded block into the bit-packing writer's command
// stream. For each partition it accepts one Rice parameter and issues a
// parameter-change command. It then accepts that partition's residuals,
// zigzag-maps each one and issues a code command (upper count, lower field,
// total length). After the last partition it issues a single flush command
// and pulses oDone.
//
// All writer-facing outputs are registered. A handshake in cycle N produces
// its command in cycle N+1. The writer never back-pressures.
//
// Optional feature: define RICE_SEQ_BITCOUNT_EN to add oBitCount. This is a
// 32-bit running total of emitted bits: oTotal for each code command plus 4
// for each parameter change. It is cleared at iStart.
//
// Ports:
//   iClock, iReset_n           clock, asynchronous active-low reset
//   iStart                     one-cycle pulse that begins a block (IDLE only)
//   iBlockSize/iPredOrder/
//   iPartOrder                 block geometry, sampled at iStart
//   iParamValid/iParam/
//   oParamReady                per-partition Rice parameter handshake
//   iResValid/iResidual/
//   oResReady                  signed residual handshake
//   oEnable                    writer command strobe
//   oChangeParam/oFlush        writer parameter-change / flush commands
//   oTotal/oUpper/oLower       code fields (0 unless a code command)
//   oRiceParam                 current clamped Rice parameter k
//   oBusy                      high from iStart until DONE exits
//   oDone                      one-cycle pulse after the flush
//   oParamErr                  one-cycle pulse when a parameter was clamped
//   oBitCount                  (RICE_SEQ_BITCOUNT_EN only) emitted bit count
// ---------------------------------------------------------------------------
module rice_partition_sequencer #(
  parameter int RES_W   = 16,
  parameter int MAX_K   = 14,
  parameter int ORDER_W = 4
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [15:0]        iBlockSize,
  input  logic [5:0]         iPredOrder,
  input  logic [ORDER_W-1:0] iPartOrder,
  input  logic               iParamValid,
  input  logic [3:0]         iParam,
  output logic               oParamReady,
  input  logic               iResValid,
  input  logic [RES_W-1:0]   iResidual,
  output logic               oResReady,
  output logic               oEnable,
  output logic               oChangeParam,
  output logic               oFlush,
  output logic [15:0]        oTotal,
  output logic [15:0]        oUpper,
  output logic [15:0]        oLower,
  output logic [3:0]         oRiceParam,
  output logic               oBusy,
  output logic               oDone,
  output logic               oParamErr
`ifdef RICE_SEQ_BITCOUNT_EN
  ,
  output logic [31:0]        oBitCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_SAMPLES,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Block geometry latched at iStart
  logic [15:0]        blk_size_q, blk_size_d;
  logic [5:0]         pred_q,     pred_d;
  logic [ORDER_W-1:0] order_q,    order_d;

  // Partition index, remaining samples in the current partition, current k
  logic [15:0] p_q,   p_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  k_q,   k_d;

  // Registered writer command outputs
  logic        busy_q,  busy_d;
  logic        en_q,    en_d;
  logic        chg_q,   chg_d;
  logic        flush_q, flush_d;
  logic [15:0] upper_q, upper_d;
  logic [15:0] lower_q, lower_d;
  logic [15:0] total_q, total_d;
  logic        perr_q,  perr_d;
  logic        done_q,  done_d;

`ifdef RICE_SEQ_BITCOUNT_EN
  logic [31:0] bitcount_q, bitcount_d;
`endif

  // -------------------------------------------------------------------------
  // Partition geometry
  // -------------------------------------------------------------------------
  logic [15:0] base_cnt;
  logic [15:0] pred_ext;
  logic [15:0] part0_cnt;
  logic [15:0] load_cnt;
  logic [15:0] part_mask;
  logic        last_part;

  assign base_cnt = blk_size_q >> order_q;
  assign pred_ext = {10'd0, pred_q};
  // A predictor order larger than the partition size leaves partition 0
  // empty rather than wrapping to a huge count.
  assign part0_cnt = (base_cnt > pred_ext) ? (base_cnt - pred_ext) : 16'd0;
  assign load_cnt  = (p_q == 16'd0) ? part0_cnt : base_cnt;
  // 2^order - 1, i.e. the index of the last partition
  assign part_mask = ~(16'hFFFF << order_q);
  assign last_part = (p_q == part_mask);

  // -------------------------------------------------------------------------
  // Parameter clamp
  // -------------------------------------------------------------------------
  logic       param_over;
  logic [3:0] param_clamped;

  assign param_over    = (iParam > 4'(MAX_K));
  assign param_clamped = param_over ? 4'(MAX_K) : iParam;

  // -------------------------------------------------------------------------
  // Zigzag map and Rice split, using the k already latched for this partition
  // -------------------------------------------------------------------------
  logic [RES_W-1:0] zz;
  logic [15:0]      u16;
  logic [15:0]      code_upper;
  logic [15:0]      code_lower;
  logic [15:0]      code_total;

  assign zz  = {iResidual[RES_W-2:0], 1'b0} ^ {RES_W{iResidual[RES_W-1]}};
  assign u16 = 16'(zz);
  assign code_upper = u16 >> k_q;
  // Leading 1 marks the terminator bit above the k low-order bits
  assign code_lower = (16'd1 << k_q) | (u16 & ((16'd1 << k_q) - 16'd1));
  assign code_total = code_upper + {12'd0, k_q} + 16'd1;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    blk_size_d = blk_size_q;
    pred_d     = pred_q;
    order_d    = order_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    busy_d     = busy_q;
    en_d       = 1'b0;
    chg_d      = 1'b0;
    flush_d    = 1'b0;
    upper_d    = 16'd0;
    lower_d    = 16'd0;
    total_d    = 16'd0;
    perr_d     = 1'b0;
    done_d     = 1'b0;
`ifdef RICE_SEQ_BITCOUNT_EN
    bitcount_d = bitcount_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          blk_size_d = iBlockSize;
          pred_d     = iPredOrder;
          order_d    = iPartOrder;
          p_d        = 16'd0;
          busy_d     = 1'b1;
`ifdef RICE_SEQ_BITCOUNT_EN
          bitcount_d = 32'd0;
`endif
          state_d    = S_PARAM;
        end
      end

      S_PARAM: begin
        if (iParamValid) begin
          k_d    = param_clamped;
          perr_d = param_over;
          en_d   = 1'b1;
          chg_d  = 1'b1;
          if (load_cnt != 16'd0) begin
            cnt_d   = load_cnt;
            state_d = S_SAMPLES;
          end else if (last_part) begin
            state_d = S_FLUSH;
          end else begin
            // Empty partition: its parameter command is still issued
            p_d     = p_q + 16'd1;
            state_d = S_PARAM;
          end
        end
      end

      S_SAMPLES: begin
        if (iResValid) begin
          en_d    = 1'b1;
          upper_d = code_upper;
          lower_d = code_lower;
          total_d = code_total;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            if (last_part) begin
              state_d = S_FLUSH;
            end else begin
              p_d     = p_q + 16'd1;
              state_d = S_PARAM;
            end
          end
        end
      end

      // The final code command becomes visible in this cycle, so the flush
      // registered here lands strictly after it.
      S_FLUSH: begin
        en_d    = 1'b1;
        flush_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef RICE_SEQ_BITCOUNT_EN
    // Accumulated in step with the command being registered
    if (en_d && chg_d) begin
      bitcount_d = bitcount_d + 32'd4;
    end else if (en_d && !flush_d) begin
      bitcount_d = bitcount_d + {16'd0, total_d};
    end
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= S_IDLE;
      blk_size_q <= 16'd0;
      pred_q     <= 6'd0;
      order_q    <= '0;
      p_q        <= 16'd0;
      cnt_q      <= 16'd0;
      k_q        <= 4'd0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      chg_q      <= 1'b0;
      flush_q    <= 1'b0;
      upper_q    <= 16'd0;
      lower_q    <= 16'd0;
      total_q    <= 16'd0;
      perr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_size_q <= blk_size_d;
      pred_q     <= pred_d;
      order_q    <= order_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      chg_q      <= chg_d;
      flush_q    <= flush_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      total_q    <= total_d;
      perr_q     <= perr_d;
      done_q     <= done_d;
    end
  end

`ifdef RICE_SEQ_BITCOUNT_EN
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      bitcount_q <= 32'd0;
    end else begin
      bitcount_q <= bitcount_d;
    end
  end

  assign oBitCount = bitcount_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign oParamReady  = (state_q == S_PARAM);
  assign oResReady    = (state_q == S_SAMPLES);
  assign oEnable      = en_q;
  assign oChangeParam = chg_q;
  assign oFlush       = flush_q;
  assign oTotal       = total_q;
  assign oUpper       = upper_q;
  assign oLower       = lower_q;
  assign oRiceParam   = k_q;
  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oParamErr    = perr_q;

endmodule

// File: tb/tb_rice_partition_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rice_partition_sequencer
//
// Directed bench for rice_partition_sequencer. Driver tasks issue block
// starts, parameters and residuals. At each accepted handshake they push the
// hand-computed writer command into a queue. A negedge monitor pops one
// entry whenever the DUT shows a command or oDone, and compares them.
// ---------------------------------------------------------------------------
module tb_rice_partition_sequencer;

  logic        iClock;
  logic        iReset_n;
  logic        iStart;
  logic [15:0] iBlockSize;
  logic [5:0]  iPredOrder;
  logic [3:0]  iPartOrder;
  logic        iParamValid;
  logic [3:0]  iParam;
  logic        oParamReady;
  logic        iResValid;
  logic [15:0] iResidual;
  logic        oResReady;
  logic        oEnable;
  logic        oChangeParam;
  logic        oFlush;
  logic [15:0] oTotal;
  logic [15:0] oUpper;
  logic [15:0] oLower;
  logic [3:0]  oRiceParam;
  logic        oBusy;
  logic        oDone;
  logic        oParamErr;
`ifdef RICE_SEQ_BITCOUNT_EN
  logic [31:0] oBitCount;
`endif

  rice_partition_sequencer #(
    .RES_W  (16),
    .MAX_K  (14),
    .ORDER_W(4)
  ) dut (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iStart      (iStart),
    .iBlockSize  (iBlockSize),
    .iPredOrder  (iPredOrder),
    .iPartOrder  (iPartOrder),
    .iParamValid (iParamValid),
    .iParam      (iParam),
    .oParamReady (oParamReady),
    .iResValid   (iResValid),
    .iResidual   (iResidual),
    .oResReady   (oResReady),
    .oEnable     (oEnable),
    .oChangeParam(oChangeParam),
    .oFlush      (oFlush),
    .oTotal      (oTotal),
    .oUpper      (oUpper),
    .oLower      (oLower),
    .oRiceParam  (oRiceParam),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oParamErr   (oParamErr)
`ifdef RICE_SEQ_BITCOUNT_EN
    ,
    .oBitCount   (oBitCount)
`endif
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  typedef enum logic [1:0] {E_CHG, E_CODE, E_FLUSH, E_DONE} kind_e;
  typedef struct {
    kind_e       kind;
    logic [3:0]  k;
    logic [15:0] upper;
    logic [15:0] lower;
    logic [15:0] total;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   done_seen    = 0;
  int   perr_seen    = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected entry per observed command or done pulse
  // ---------------------------------------------------------------------------
  always @(negedge iClock) begin
    if (iReset_n) begin
      if (oParamErr) perr_seen++;
      if (oDone) done_seen++;
      if (oEnable || oChangeParam || oFlush || oDone) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {oEnable, oChangeParam, oFlush, oDone}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          case (mon_e.kind)
            E_CHG: check("chg_cmd",
              {oEnable, oChangeParam, oFlush, oDone, oBusy, oRiceParam,
               oUpper, oLower, oTotal},
              {5'b11001, mon_e.k, 48'd0});
            E_CODE: check("code_cmd",
              {oEnable, oChangeParam, oFlush, oDone, oBusy, oRiceParam,
               oUpper, oLower, oTotal},
              {5'b10001, mon_e.k, mon_e.upper, mon_e.lower, mon_e.total});
            E_FLUSH: check("flush_cmd",
              {oEnable, oChangeParam, oFlush, oDone, oUpper, oLower, oTotal},
              {4'b1010, 48'd0});
            default: check("done_pulse",
              {oEnable, oChangeParam, oFlush, oDone}, 64'b0001);
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic start_block(input logic [15:0] size, input logic [5:0] pred,
                             input logic [3:0] order);
    iBlockSize = size;
    iPredOrder = pred;
    iPartOrder = order;
    iStart     = 1'b1;
    tick();
    iStart     = 1'b0;
  endtask

  task automatic send_param(input logic [3:0] kin, input logic [3:0] kexp);
    bit got;
    got         = 1'b0;
    iParamValid = 1'b1;
    iParam      = kin;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge iClock);
      got = oParamReady;
      if (got) begin
        check("res_ready_in_param", {63'd0, oResReady}, 64'd0);
        exp_q.push_back('{kind: E_CHG, k: kexp, upper: 16'd0, lower: 16'd0,
                          total: 16'd0});
      end
      tick();
    end
    iParamValid = 1'b0;
    check("param_handshake", {63'd0, got}, 64'd1);
  endtask

  // gap > 0 idles iResValid for that many cycles after the handshake and
  // checks the code command appears exactly one cycle after acceptance.
  task automatic send_res(input logic signed [15:0] r, input logic [3:0] k,
                          input logic [15:0] up, input logic [15:0] lo,
                          input logic [15:0] tot, input int gap);
    bit got;
    got       = 1'b0;
    iResValid = 1'b1;
    iResidual = r;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge iClock);
      got = oResReady;
      if (got) begin
        exp_q.push_back('{kind: E_CODE, k: k, upper: up, lower: lo, total: tot});
      end
      tick();
    end
    iResValid = 1'b0;
    check("res_handshake", {63'd0, got}, 64'd1);
    if (gap > 0) begin
      @(negedge iClock);
      check("code_latency", {63'd0, oEnable}, 64'd1);
      tick();
      repeat (gap - 1) tick();
    end
  endtask

  task automatic end_block(input int done_before);
    int i;
    exp_q.push_back('{kind: E_FLUSH, k: 4'd0, upper: 16'd0, lower: 16'd0,
                      total: 16'd0});
    exp_q.push_back('{kind: E_DONE, k: 4'd0, upper: 16'd0, lower: 16'd0,
                      total: 16'd0});
    i = 0;
    while (i < 40 && done_seen == done_before) begin
      tick();
      i++;
    end
    check("done_seen", 64'(done_seen - done_before), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Single partition, k = 2, residuals {-3, 0, 5, -1}
  task automatic run_single();
    int d0;
    int e0;
    d0 = done_seen;
    e0 = perr_seen;
    start_block(16'd4, 6'd0, 4'd0);
    send_param(4'd2, 4'd2);
    send_res(-16'sd3, 4'd2, 16'd1, 16'd5, 16'd4, 0);
    send_res(16'sd0,  4'd2, 16'd0, 16'd4, 16'd3, 0);
    send_res(16'sd5,  4'd2, 16'd2, 16'd6, 16'd5, 0);
    send_res(-16'sd1, 4'd2, 16'd0, 16'd5, 16'd3, 0);
    end_block(d0);
    check("single_no_param_err", 64'(perr_seen - e0), 64'd0);
`ifdef RICE_SEQ_BITCOUNT_EN
    check("single_bitcount", {32'd0, oBitCount}, 64'd19);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d0;
    int e0;
    iReset_n    = 1'b0;
    iStart      = 1'b0;
    iBlockSize  = 16'd0;
    iPredOrder  = 6'd0;
    iPartOrder  = 4'd0;
    iParamValid = 1'b0;
    iParam      = 4'd0;
    iResValid   = 1'b0;
    iResidual   = 16'd0;

    #12;
    check("reset_outputs",
      {oParamReady, oResReady, oEnable, oChangeParam, oFlush, oTotal, oUpper,
       oLower, oRiceParam, oBusy, oDone, oParamErr}, 64'd0);
    tick();
    iReset_n = 1'b1;
    tick();

    // Residuals offered in IDLE are never accepted
    iResValid = 1'b1;
    iResidual = 16'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClock);
      check("idle_res_ready", {63'd0, oResReady}, 64'd0);
      tick();
    end
    iResValid = 1'b0;

    run_single();

    // Two partitions, pred 2; iStart mid-block must be ignored
    d0 = done_seen;
    start_block(16'd8, 6'd2, 4'd1);
    send_param(4'd0, 4'd0);
    iBlockSize = 16'd16;
    iStart     = 1'b1;
    tick();
    iStart     = 1'b0;
    send_res(16'sd0,   4'd0, 16'd0,  16'd1,  16'd1,  0);
    send_res(16'sd1,   4'd0, 16'd2,  16'd1,  16'd3,  0);
    send_param(4'd3, 4'd3);
    send_res(-16'sd1,  4'd3, 16'd0,  16'd9,  16'd4,  0);
    send_res(16'sd7,   4'd3, 16'd1,  16'd14, 16'd5,  0);
    send_res(-16'sd8,  4'd3, 16'd1,  16'd15, 16'd5,  0);
    send_res(16'sd100, 4'd3, 16'd25, 16'd8,  16'd29, 0);
    end_block(d0);

    // Residuals arriving every other cycle
    d0 = done_seen;
    start_block(16'd3, 6'd0, 4'd0);
    send_param(4'd1, 4'd1);
    send_res(16'sd2,  4'd1, 16'd2, 16'd2, 16'd4, 1);
    send_res(-16'sd2, 4'd1, 16'd1, 16'd3, 16'd3, 1);
    send_res(16'sd3,  4'd1, 16'd3, 16'd2, 16'd5, 1);
    end_block(d0);

    // Clamp of k = 15 to 14
    d0 = done_seen;
    e0 = perr_seen;
    start_block(16'd1, 6'd0, 4'd0);
    send_param(4'd15, 4'd14);
    send_res(16'sd16384, 4'd14, 16'd2, 16'd16384, 16'd17, 0);
    end_block(d0);
    check("clamp_param_err_once", 64'(perr_seen - e0), 64'd1);

    // Four empty partitions: four parameter commands, then flush
    d0 = done_seen;
    start_block(16'd2, 6'd0, 4'd2);
    send_param(4'd1, 4'd1);
    send_param(4'd2, 4'd2);
    send_param(4'd3, 4'd3);
    send_param(4'd4, 4'd4);
    end_block(d0);
`ifdef RICE_SEQ_BITCOUNT_EN
    check("empty_bitcount", {32'd0, oBitCount}, 64'd16);
`endif

    // Reset during SAMPLES of partition 1
    start_block(16'd4, 6'd0, 4'd1);
    send_param(4'd0, 4'd0);
    send_res(16'sd0, 4'd0, 16'd0, 16'd1, 16'd1, 0);
    send_res(16'sd1, 4'd0, 16'd2, 16'd1, 16'd3, 0);
    send_param(4'd1, 4'd1);
    send_res(16'sd2, 4'd1, 16'd2, 16'd2, 16'd4, 0);
    tick();
    tick();
    check("pre_reset_queue", 64'(exp_q.size()), 64'd0);
    iReset_n = 1'b0;
    #1;
    check("midblock_reset_outputs",
      {oParamReady, oResReady, oEnable, oChangeParam, oFlush, oTotal, oUpper,
       oLower, oRiceParam, oBusy, oDone, oParamErr}, 64'd0);
    tick();
    tick();
    exp_q.delete();
    iReset_n = 1'b1;
    tick();

    run_single();

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared,
             n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
